// File: rtl/sort_ctrl_if.sv
// Shared sorter geometry plus the stream-side handshake bundle for sort_ctrl.
package sort_pkg;
    localparam int M = 8;  // elements per input vector
    localparam int N = 8;  // bits per element
    localparam int W = 4;  // smallest elements kept / sorter stages
endpackage

interface sort_ctrl_if;
    import sort_pkg::*;

    logic                s_valid;
    logic                s_ready;
    logic [M-1:0][N-1:0] s_data;
    logic                m_valid;
    logic                m_ready;
    logic [W-1:0][N-1:0] m_data;

    // slave: the controller; master: whoever feeds vectors and drains results
    modport slave  (input  s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
    modport master (output s_valid, s_data, m_ready, input  s_ready, m_valid, m_data);
endinterface

// File: rtl/sort_ctrl.sv
// Flow controller for the pipelined min-extraction sorter: credit-based input
// acceptance, tag tracking through the non-stallable sorter, per-lane deskew
// and an in-order output FIFO.

// One deskew lane: fixed DLY-cycle delay line, DLY >= 1. Data only; the
// validity of the aligned word is carried by the tag pipe in the parent.
module sort_deskew_lane #(
    parameter int N   = 8,
    parameter int DLY = 1
) (
    input  logic         clk,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    logic [DLY-1:0][N-1:0] sr;

    // shift the lane value DLY stages
    always_ff @(posedge clk) begin
        sr[0] <= d;
        for (int k = 1; k < DLY; k++) sr[k] <= sr[k-1];
    end

    assign q = sr[DLY-1];
endmodule

module sort_ctrl
    import sort_pkg::*;
#(
    parameter int DEPTH = W + 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    sort_ctrl_if.slave                   sif,
    output logic [M-1:0][N-1:0]          o_chi,
    input  logic [W-1:0][N-1:0]          i_y_q,
    input  logic                         i_flush,
    output logic [$clog2(DEPTH+1)-1:0]   o_used,
    output logic                         o_busy
);
    localparam int UW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [W:0]          vld_pipe;   // tag per sorter stage; [W] marks the aligned word
    logic [W-1:0][N-1:0] y_al;
    logic [W-1:0][N-1:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [UW-1:0]       used;       // in flight + buffered credits
    logic [UW-1:0]       cnt;        // buffered entries only
    logic                acc, pop, wr;

    // pointer increment with explicit wrap so non-power-of-2 depths work
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // s_ready comes from the credit register only; a pop frees its credit next cycle
    assign sif.s_ready = (used < UW'(DEPTH));
    assign sif.m_valid = (cnt != '0);
    assign sif.m_data  = mem[rd_ptr];
    assign acc         = sif.s_valid & sif.s_ready;
    assign pop         = sif.m_valid & sif.m_ready;
    assign wr          = vld_pipe[W];
    assign o_used      = used;
    assign o_busy      = (used != '0);

    // lane i emerges i cycles after lane 0; delay it W-1-i so all meet at tag[W]
    for (genvar i = 0; i < W - 1; i++) begin : g_lane
        sort_deskew_lane #(.N(N), .DLY(W - 1 - i)) u_lane (
            .clk (clk),
            .d   (i_y_q[i]),
            .q   (y_al[i])
        );
    end
    assign y_al[W-1] = i_y_q[W-1];

    // control state: tags, pointers, credits and the sorter input register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            used     <= '0;
            cnt      <= '0;
            o_chi    <= '0;
        end else if (i_flush) begin
            // words still in the sorter retire with tag 0 and are dropped
            vld_pipe <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            used     <= '0;
            cnt      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[W-1:0], acc};
            if (acc) o_chi  <= sif.s_data;
            if (wr)  wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            used <= used + UW'(acc) - UW'(pop);
            cnt  <= cnt + UW'(wr) - UW'(pop);
        end
    end

    // FIFO storage; credits guarantee a free slot whenever an aligned word lands
    always_ff @(posedge clk) begin
        if (rst_n && !i_flush && wr) mem[wr_ptr] <= y_al;
    end
endmodule

// File: tb/tb_sort_ctrl.sv
// Directed bench for sort_ctrl with a behavioural model of the W-stage sorter.
module tb_sort_ctrl;
    import sort_pkg::*;

    localparam int DEPTH = 7;
    typedef logic [M-1:0][N-1:0] vec_t;
    typedef logic [W-1:0][N-1:0] res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_flush = 1'b0;
    vec_t       o_chi;
    res_t       i_y_q;
    logic [2:0] o_used;
    logic       o_busy;

    int n_chk = 0, n_err = 0, n_res = 0, ovf = 0, mvbad = 0, occ = 0;
    res_t sb[$];
    logic [W:0] tp = '0;
    res_t st [W];

    sort_ctrl_if sif();

    sort_ctrl #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sif     (sif),
        .o_chi   (o_chi),
        .i_y_q   (i_y_q),
        .i_flush (i_flush),
        .o_used  (o_used),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    function automatic res_t ref_sort(input vec_t v);
        int a[M];
        int t;
        res_t r;
        for (int i = 0; i < M; i++) a[i] = int'(v[i]);
        for (int i = 1; i < M; i++)
            for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
                t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
        for (int k = 0; k < W; k++) r[k] = N'(a[k]);
        return r;
    endfunction

    function automatic vec_t rvec();
        vec_t v;
        for (int k = 0; k < M; k++) v[k] = N'($urandom);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // sorter model: lane i of the sorted o_chi appears i+1 cycles after o_chi
    always @(posedge clk) begin
        st[0] <= ref_sort(o_chi);
        for (int k = 1; k < W; k++) st[k] <= st[k-1];
    end

    always_comb begin
        i_y_q = '0;
        for (int i = 0; i < W; i++) i_y_q[i] = st[i][i];
    end

    // scoreboard plus shadow FIFO occupancy
    always @(posedge clk) begin
        if (!rst_n || i_flush) begin
            sb.delete();
            tp = '0;
            occ = 0;
        end else begin
            if (tp[W] && occ == DEPTH) ovf++;
            if (sif.m_valid && sif.m_ready) begin
                n_res++;
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else chk("result", sif.m_data, sb.pop_front());
            end
            occ = occ + int'(tp[W]) - int'(sif.m_valid && sif.m_ready);
            tp = {tp[W-1:0], sif.s_valid && sif.s_ready};
            if (sif.s_valid && sif.s_ready) sb.push_back(ref_sort(sif.s_data));
        end
    end

    always @(negedge clk) if (rst_n && (sif.m_valid !== (occ != 0))) mvbad++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // accept v in cycle 0 on an idle controller, expect it only in cycle 6
    task automatic single_vec(input vec_t v, input res_t exp);
        sif.s_valid = 1'b1;
        sif.s_data  = v;
        step();
        sif.s_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk("sv_mvalid", sif.m_valid, c == 6);
            if (c == 6) chk("sv_data", sif.m_data, exp);
            if (c == 6) chk("sv_used6", o_used, 1);
            if (c == 7) chk("sv_used7", o_used, 0);
            step();
        end
    endtask

    initial begin
        int n0, bad, drop, acc, mv;
        vec_t v1, v2, v3;
        v1 = {8'd6, 8'd2, 8'd8, 8'd5, 8'd1, 8'd9, 8'd3, 8'd7};
        v2 = {8'd9, 8'd3, 8'd77, 8'd0, 8'd255, 8'd10, 8'd10, 8'd200};
        v3 = {8'd0, 8'd0, 8'd9, 8'd9, 8'd1, 8'd1, 8'd4, 8'd4};

        // reset with s_valid held high
        sif.s_valid = 1'b1;
        sif.s_data  = v1;
        sif.m_ready = 1'b1;
        repeat (3) begin
            step();
            chk("rst_sready", sif.s_ready, 1);
            chk("rst_mvalid", sif.m_valid, 0);
            chk("rst_used", o_used, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_chi", o_chi, 0);
        end
        rst_n = 1'b1;
        step();
        chk("rst_first_acc", o_used, 1);
        chk("rst_first_busy", o_busy, 1);
        sif.s_valid = 1'b0;
        repeat (10) step();
        chk("idle_used", o_used, 0);

        // single vector
        single_vec(v1, {8'd5, 8'd3, 8'd2, 8'd1});

        // streaming, 20 back-to-back
        n0 = n_res; bad = 0; drop = 0;
        for (int c = 0; c < 32; c++) begin
            if (c < 20) begin
                sif.s_valid = 1'b1;
                sif.s_data  = rvec();
                if (!sif.s_ready) drop++;
            end else sif.s_valid = 1'b0;
            if (sif.m_valid !== (c >= 6 && c <= 25)) bad++;
            step();
        end
        chk("st_drop", drop, 0);
        chk("st_timing", bad, 0);
        chk("st_count", n_res - n0, 20);

        // backpressure
        sif.m_ready = 1'b0; acc = 0;
        for (int c = 0; c < 14; c++) begin
            sif.s_valid = 1'b1;
            sif.s_data  = rvec();
            if (sif.s_ready) acc++;
            step();
        end
        chk("bp_acc", acc, 7);
        chk("bp_sready", sif.s_ready, 0);
        chk("bp_used", o_used, 7);
        chk("bp_mvalid", sif.m_valid, 1);
        sif.s_valid = 1'b0;
        sif.m_ready = 1'b1;
        n0 = n_res;
        chk("bp_sready_pop", sif.s_ready, 0);
        step();
        chk("bp_sready_next", sif.s_ready, 1);
        chk("bp_used6", o_used, 6);
        repeat (10) step();
        chk("bp_count", n_res - n0, 7);
        chk("bp_drained", o_used, 0);

        // flush: 2 buffered + 3 in flight, accept in flush cycle discarded
        sif.m_ready = 1'b0;
        n0 = n_res;
        for (int c = 0; c < 7; c++) begin
            sif.s_valid = (c < 2 || c >= 4);
            sif.s_data  = rvec();
            step();
        end
        chk("fl_pre_used", o_used, 5);
        chk("fl_pre_mvalid", sif.m_valid, 1);
        sif.s_valid = 1'b1;
        sif.s_data  = rvec();
        i_flush = 1'b1;
        chk("fl_sready", sif.s_ready, 1);
        step();
        i_flush = 1'b0;
        sif.s_valid = 1'b0;
        sif.m_ready = 1'b1;
        chk("fl_used", o_used, 0);
        chk("fl_mvalid", sif.m_valid, 0);
        chk("fl_busy", o_busy, 0);
        mv = 0;
        repeat (12) begin
            if (sif.m_valid) mv++;
            step();
        end
        chk("fl_none", mv, 0);
        chk("fl_nres", n_res - n0, 0);
        single_vec(v2, {8'd10, 8'd9, 8'd3, 8'd0});

        // simultaneous pop with s_valid at full, then accept+pop
        sif.m_ready = 1'b0;
        for (int c = 0; c < 14; c++) begin
            sif.s_valid = 1'b1;
            sif.s_data  = rvec();
            step();
        end
        chk("sim_full", o_used, 7);
        sif.m_ready = 1'b1;
        sif.s_data  = rvec();
        chk("sim_sready0", sif.s_ready, 0);
        step();
        chk("sim_used6", o_used, 6);
        chk("sim_sready1", sif.s_ready, 1);
        chk("sim_mvalid", sif.m_valid, 1);
        sif.s_data = rvec();
        step();
        chk("sim_hold", o_used, 6);
        sif.s_valid = 1'b0;
        repeat (12) step();
        chk("sim_drained", o_used, 0);

        // reset mid-stream
        n0 = n_res;
        for (int c = 0; c < 5; c++) begin
            sif.s_valid = 1'b1;
            sif.s_data  = rvec();
            step();
        end
        sif.s_data = rvec();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sif.s_valid = 1'b0;
        chk("mr_used", o_used, 0);
        chk("mr_mvalid", sif.m_valid, 0);
        chk("mr_chi", o_chi, 0);
        chk("mr_sready", sif.s_ready, 1);
        chk("mr_busy", o_busy, 0);
        repeat (12) step();
        chk("mr_nres", n_res - n0, 0);
        single_vec(v3, {8'd1, 8'd1, 8'd0, 8'd0});

        chk("no_overfill", ovf, 0);
        chk("mvalid_model", mvbad, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
